// File: rtl/fetch_inst_queue_pkg.sv
// fetch_inst_queue_pkg
//   Shared fetch-path constants used by the instruction queue and the
//   jump-processing stage: entry width, bundle size, PC / instruction
//   field placement inside an entry and the default queue depth.
//   Helper functions pack and unpack queue entries.
package fetch_inst_queue_pkg;

    localparam int unsigned FIQ_ENTRY_W    = 64;
    localparam int unsigned FIQ_MAX_BUNDLE = 10;
    localparam int unsigned FIQ_DEPTH      = 16;

    localparam int unsigned FIQ_PC_LSB     = 32;
    localparam int unsigned FIQ_PC_W       = 32;
    localparam int unsigned FIQ_INST_LSB   = 0;
    localparam int unsigned FIQ_INST_W     = 32;

    function automatic logic [FIQ_ENTRY_W-1:0] make_entry(
        input logic [FIQ_PC_W-1:0]   pc,
        input logic [FIQ_INST_W-1:0] inst
    );
        logic [FIQ_ENTRY_W-1:0] e;
        e = '0;
        e[FIQ_PC_LSB   +: FIQ_PC_W]   = pc;
        e[FIQ_INST_LSB +: FIQ_INST_W] = inst;
        return e;
    endfunction

    function automatic logic [FIQ_PC_W-1:0] entry_pc(input logic [FIQ_ENTRY_W-1:0] e);
        return e[FIQ_PC_LSB +: FIQ_PC_W];
    endfunction

    function automatic logic [FIQ_INST_W-1:0] entry_inst(input logic [FIQ_ENTRY_W-1:0] e);
        return e[FIQ_INST_LSB +: FIQ_INST_W];
    endfunction

endpackage

// File: rtl/fetch_inst_queue_iq_storage.sv
// iq_storage
//   DEPTH x ENTRY_W register array for the fetch instruction queue.
//   NWR independent write ports (one per bundle slot) and two
//   combinational read ports (queue head and head+1). Contents are
//   never reset; the owner tracks validity.
// Ports
//   clk      rising-edge clock
//   wr_en    per-port write enable
//   wr_addr  per-port write index
//   wr_data  per-port write data
//   rd_addr0 / rd_addr1  read indices
//   rd_data0 / rd_data1  read data
module iq_storage #(
    parameter  int unsigned DEPTH   = 16,
    parameter  int unsigned ENTRY_W = 64,
    parameter  int unsigned NWR     = 10,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic [NWR-1:0]     wr_en,
    input  logic [AW-1:0]      wr_addr [NWR],
    input  logic [ENTRY_W-1:0] wr_data [NWR],
    input  logic [AW-1:0]      rd_addr0,
    input  logic [AW-1:0]      rd_addr1,
    output logic [ENTRY_W-1:0] rd_data0,
    output logic [ENTRY_W-1:0] rd_data1
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Write addresses within one bundle are always distinct, so port order
    // never matters.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < NWR; p++) begin
            if (wr_en[p]) begin
                mem[wr_addr[p]] <= wr_data[p];
            end
        end
    end

    always_comb begin
        rd_data0 = mem[rd_addr0];
        rd_data1 = mem[rd_addr1];
    end

endmodule

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue
//   Circular instruction queue between the fetch alignment stage and
//   decode. Accepts a whole aligned bundle (up to MAX_BUNDLE entries) or
//   nothing, and presents up to two entries per cycle to decode.
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   i_flush          redirect flush, empties the queue on the next edge
//   i_bundleValid    bundle offered
//   o_bundleReady    whole offered bundle fits (registered occupancy)
//   i_bundle_640     aligned entries, entry k at [k*ENTRY_W +: ENTRY_W]
//   i_bundleCount_4  number of leading entries to keep
//   o_deqValid_2     bit n: head+n holds a valid entry
//   i_deqReady_2     decode consumes slot n
//   o_deqEntry0_64   entry at head
//   o_deqEntry1_64   entry at head+1
//   o_count_5        current occupancy
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter  int unsigned DEPTH      = FIQ_DEPTH,
    parameter  int unsigned ENTRY_W    = FIQ_ENTRY_W,
    parameter  int unsigned MAX_BUNDLE = FIQ_MAX_BUNDLE,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned CNT_W      = PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,
    input  logic                          i_bundleValid,
    output logic                          o_bundleReady,
    input  logic [MAX_BUNDLE*ENTRY_W-1:0] i_bundle_640,
    input  logic [3:0]                    i_bundleCount_4,
    output logic [1:0]                    o_deqValid_2,
    input  logic [1:0]                    i_deqReady_2,
    output logic [ENTRY_W-1:0]            o_deqEntry0_64,
    output logic [ENTRY_W-1:0]            o_deqEntry1_64,
    output logic [CNT_W-1:0]              o_count_5
);

    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic [3:0]            req_cnt;
    logic [3:0]            enq_cnt;
    logic [CNT_W-1:0]      free_slots;
    logic                  bundle_ready;
    logic                  enq_fire;
    logic                  pop0;
    logic                  pop1;
    logic [1:0]            pop_cnt;

    logic [MAX_BUNDLE-1:0] wr_en;
    logic [PTR_W-1:0]      wr_addr [MAX_BUNDLE];
    logic [ENTRY_W-1:0]    wr_data [MAX_BUNDLE];

    // Admission uses only registered occupancy, so this cycle's pops
    // cannot free room; this keeps i_deqReady_2 off the ready path.
    always_comb begin
        req_cnt      = (i_bundleCount_4 > 4'(MAX_BUNDLE)) ? 4'(MAX_BUNDLE) : i_bundleCount_4;
        free_slots   = CNT_W'(DEPTH) - count;
        bundle_ready = !i_flush && (free_slots >= CNT_W'(req_cnt));
        enq_fire     = i_bundleValid && bundle_ready;
        enq_cnt      = enq_fire ? req_cnt : '0;
    end

    // Slot 1 may only pop together with slot 0 to keep decode in order.
    always_comb begin
        pop0    = (count != '0) && i_deqReady_2[0];
        pop1    = pop0 && (count >= CNT_W'(2)) && i_deqReady_2[1];
        pop_cnt = pop1 ? 2'd2 : (pop0 ? 2'd1 : 2'd0);
    end

    always_comb begin
        for (int unsigned p = 0; p < MAX_BUNDLE; p++) begin
            wr_en[p]   = enq_fire && (4'(p) < req_cnt);
            wr_addr[p] = tail + PTR_W'(p);
            wr_data[p] = i_bundle_640[p*ENTRY_W +: ENTRY_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_cnt);
            tail  <= tail + PTR_W'(enq_cnt);
            count <= count + CNT_W'(enq_cnt) - CNT_W'(pop_cnt);
        end
    end

    iq_storage #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W),
        .NWR     (MAX_BUNDLE)
    ) u_storage (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (head),
        .rd_addr1 (head + PTR_W'(1)),
        .rd_data0 (o_deqEntry0_64),
        .rd_data1 (o_deqEntry1_64)
    );

    always_comb begin
        o_bundleReady   = bundle_ready;
        o_deqValid_2[0] = (count != '0);
        o_deqValid_2[1] = (count >= CNT_W'(2));
        o_count_5       = count;
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb_fetch_inst_queue
//   Scoreboard bench for fetch_inst_queue. The driver issues bundles and
//   pushes every accepted entry (tagged with the cycle it becomes visible)
//   into a FIFO scoreboard; the monitor, on every falling edge, compares
//   occupancy, valid bits, ready and the presented entries against the
//   scoreboard and retires popped / flushed entries.
module tb_fetch_inst_queue;
    import fetch_inst_queue_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned EW    = 64;
    localparam int unsigned MB    = 10;

    logic              clk;
    logic              rst;
    logic              i_flush;
    logic              i_bundleValid;
    logic              o_bundleReady;
    logic [MB*EW-1:0]  i_bundle_640;
    logic [3:0]        i_bundleCount_4;
    logic [1:0]        o_deqValid_2;
    logic [1:0]        i_deqReady_2;
    logic [EW-1:0]     o_deqEntry0_64;
    logic [EW-1:0]     o_deqEntry1_64;
    logic [4:0]        o_count_5;

    fetch_inst_queue #(
        .DEPTH      (DEPTH),
        .ENTRY_W    (EW),
        .MAX_BUNDLE (MB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_flush         (i_flush),
        .i_bundleValid   (i_bundleValid),
        .o_bundleReady   (o_bundleReady),
        .i_bundle_640    (i_bundle_640),
        .i_bundleCount_4 (i_bundleCount_4),
        .o_deqValid_2    (o_deqValid_2),
        .i_deqReady_2    (i_deqReady_2),
        .o_deqEntry0_64  (o_deqEntry0_64),
        .o_deqEntry1_64  (o_deqEntry1_64),
        .o_count_5       (o_count_5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [EW-1:0] data;
        int unsigned   land;
    } sb_t;

    sb_t          sb[$];
    int unsigned  cyc = 0;
    int           checks = 0;
    int           failures = 0;
    logic         exp_ready;
    logic [31:0]  pc_next;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned visible();
        int unsigned v = 0;
        foreach (sb[i]) if (sb[i].land <= cyc) v++;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", name, cyc, got, want);
        end
    endtask

    // Monitor: compare presented state against the scoreboard, then retire.
    always @(negedge clk) begin
        int unsigned vis;
        logic p0, p1;
        vis = visible();
        check("count", 64'(o_count_5), 64'(vis));
        check("deq_valid", 64'(o_deqValid_2), {62'd0, vis >= 2, vis >= 1});
        check("bundle_ready", 64'(o_bundleReady), 64'(exp_ready));
        if (vis >= 1) check("slot0_entry", o_deqEntry0_64, sb[0].data);
        if (vis >= 2) check("slot1_entry", o_deqEntry1_64, sb[1].data);
        if (rst) begin
            if (i_flush) begin
                sb.delete();
            end else begin
                p0 = (vis >= 1) && i_deqReady_2[0];
                p1 = p0 && (vis >= 2) && i_deqReady_2[1];
                if (p0) void'(sb.pop_front());
                if (p1) void'(sb.pop_front());
            end
        end
    end

    // Driver: one call per cycle, inputs applied 1 time unit after the edge.
    task automatic drive(input logic v, input logic [3:0] n, input logic [1:0] rdy,
                         input logic fl, input logic r);
        logic [EW-1:0] ent [MB];
        int unsigned   keep;
        @(posedge clk);
        #1;
        rst = r;
        if (!r) sb.delete();
        for (int unsigned k = 0; k < MB; k++) begin
            ent[k] = make_entry(pc_next + 32'(4 * k), $urandom);
            i_bundle_640[k*EW +: EW] = ent[k];
        end
        i_bundleValid   = v;
        i_bundleCount_4 = n;
        i_deqReady_2    = rdy;
        i_flush         = fl;
        keep      = (int'(n) > MB) ? MB : int'(n);
        exp_ready = !fl && ((DEPTH - visible()) >= keep);
        if (r && v && exp_ready) begin
            for (int unsigned k = 0; k < keep; k++) sb.push_back('{data: ent[k], land: cyc + 1});
            pc_next = pc_next + 32'(4 * keep);
        end
    endtask

    task automatic idle(input logic [1:0] rdy);
        drive(1'b0, 4'd0, rdy, 1'b0, 1'b1);
    endtask

    initial begin
        rst             = 1'b0;
        i_flush         = 1'b0;
        i_bundleValid   = 1'b0;
        i_bundleCount_4 = 4'd0;
        i_deqReady_2    = 2'b00;
        i_bundle_640    = '0;
        exp_ready       = 1'b1;
        pc_next         = 32'h100;

        // Reset, with a bundle offered while held in reset (dropped).
        drive(1'b1, 4'd10, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 4'd0,  2'b00, 1'b0, 1'b0);
        pc_next = 32'h100;

        // Fill to 10 (PCs 0x100..0x124), then admission boundaries.
        drive(1'b1, 4'd10, 2'b00, 1'b0, 1'b1);
        drive(1'b1, 4'd7,  2'b00, 1'b0, 1'b1);
        drive(1'b1, 4'd6,  2'b00, 1'b0, 1'b1);
        drive(1'b1, 4'd1,  2'b00, 1'b0, 1'b1);
        // Full queue: pop 2 with offer 2 -> offer rejected, count 14.
        drive(1'b1, 4'd2,  2'b11, 1'b0, 1'b1);
        idle(2'b00);

        // Flush with a same-cycle bundle; next bundle starts at index 0.
        drive(1'b0, 4'd0, 2'b00, 1'b1, 1'b1);
        drive(1'b1, 4'd5, 2'b00, 1'b0, 1'b1);
        drive(1'b1, 4'd3, 2'b11, 1'b1, 1'b1);
        drive(1'b1, 4'd2, 2'b00, 1'b0, 1'b1);
        idle(2'b00);

        // Single entry: slot 1 alone pops nothing, 11 pops just one.
        drive(1'b0, 4'd0, 2'b00, 1'b1, 1'b1);
        drive(1'b1, 4'd1, 2'b00, 1'b0, 1'b1);
        idle(2'b10);
        idle(2'b11);
        idle(2'b11);

        // Zero-count and over-limit counts.
        drive(1'b1, 4'd0,  2'b00, 1'b0, 1'b1);
        drive(1'b1, 4'd15, 2'b00, 1'b0, 1'b1);
        drive(1'b0, 4'd0,  2'b00, 1'b1, 1'b1);

        // Wrap: advance head/tail to 14, then 4 entries cross 15 -> 0.
        drive(1'b1, 4'd10, 2'b00, 1'b0, 1'b1);
        drive(1'b1, 4'd4,  2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) idle(2'b11);
        drive(1'b1, 4'd4, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle(2'b11);

        // Reset asserted mid-bundle, then first bundle after release.
        drive(1'b1, 4'd8, 2'b01, 1'b0, 1'b0);
        drive(1'b1, 4'd5, 2'b00, 1'b0, 1'b1);
        idle(2'b01);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, 4'($urandom % 16), 2'($urandom % 4),
                  ($urandom % 50) == 0, ($urandom % 400) != 0);
        end

        for (int i = 0; i < 12; i++) idle(2'b11);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_inst_queue.md
FETCH_INST_QUEUE -- requirements
Module: fetch_inst_queue

Interface
REQ-001 Parameter DEPTH, default 16, queue entries; power of two, at least 10.
REQ-002 Parameter ENTRY_W, default 64, entry width: bits [63:32] PC, bits [31:0] instruction word.
REQ-003 Parameter MAX_BUNDLE, default 10, maximum instructions per fetch bundle.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 i_flush  input  1  synchronous flush from the redirect path (backend error or predicted jump).
REQ-007 i_bundleValid  input  1  aligned bundle offered.
REQ-008 o_bundleReady  output  1  queue accepts the whole offered bundle this cycle.
REQ-009 i_bundle_640  input  MAX_BUNDLE*ENTRY_W  aligned instruction table; entry k at bits [k*64 +: 64].
REQ-010 i_bundleCount_4  input  4  number of leading entries to keep: cut position + 1 when a jump is taken, otherwise the aligned instruction number.
REQ-011 o_deqValid_2  output  2  bit n means head+n holds a valid entry.
REQ-012 i_deqReady_2  input  2  decode consumes slot n.
REQ-013 o_deqEntry0_64, o_deqEntry1_64  output  64 each  entries at head and head+1.
REQ-014 o_count_5  output  log2(DEPTH)+1  current occupancy.

Function
REQ-015 Storage is a circular buffer with head and tail pointers (log2(DEPTH) bits, wrap modulo DEPTH) and an occupancy counter.
REQ-016 o_bundleReady = !i_flush && (DEPTH - count) >= i_bundleCount_4, using the registered count before this cycle's dequeue; the check is deliberately conservative.
REQ-017 Enqueue is all-or-nothing: on valid&&ready, entries 0..cnt-1 are written to tail..tail+cnt-1 (mod DEPTH) and tail advances by cnt in the same edge.
REQ-018 i_bundleCount_4 = 0 with valid is a no-op: ready asserts, nothing is written.
REQ-019 i_bundleCount_4 > MAX_BUNDLE is clamped to MAX_BUNDLE.
REQ-020 o_deqValid_2[0] = count>=1; o_deqValid_2[1] = count>=2; entries are read combinationally from head and head+1 (mod DEPTH).
REQ-021 Pop count = v0&r0 + (v0&r0&v1&r1); slot 1 never pops without slot 0; head advances by the pop count.
REQ-022 With simultaneous enqueue and dequeue, next count = count + enqCnt - popCnt.
REQ-023 i_flush has priority: head, tail and count go to 0 on the next edge; same-cycle enqueue and dequeue are discarded; o_deqValid_2 is still driven from current state during the flush cycle, but the decode stage ignores it.
REQ-024 No combinational path from i_deqReady_2 to o_bundleReady.
REQ-025 Latency: an entry enqueued at edge N is visible on the dequeue outputs after edge N (next cycle).
REQ-026 Storage contents are not reset; validity derives only from count.

Reset
REQ-027 On rst low, head = tail = count = 0 immediately, o_deqValid_2 = 2'b00, o_count_5 = 0, and o_bundleReady = 1 for any count <= MAX_BUNDLE.
REQ-028 Reset deassertion mid-bundle drops that bundle; the first accepted bundle after release starts at entry 0.

Structure
REQ-029 A shared fetch package holds ENTRY_W, MAX_BUNDLE, the PC/instruction field offsets and the default DEPTH, so this block and the jump-processing stage stay consistent.
REQ-030 One sub-module, iq_storage, holds the DEPTH x ENTRY_W register array with up to MAX_BUNDLE write ports and 2 read ports; pointer and count logic stay in the top.

Verification
REQ-031 Reset, then a bundle of count 10 with PCs 0x100..0x124 -> o_count_5 = 10; slot0 PC 0x100; slot1 PC 0x104.
REQ-032 count = 10, offer count 7 -> o_bundleReady = 0 (6 free); offer count 6 -> accepted, count = 16, then o_bundleReady = 0 for count 1.
REQ-033 Wrap-around: head = tail = 14, enqueue 4 entries, dequeue 2 per cycle -> PCs emerge in order across index 15 -> 0 and count returns to 0.
REQ-034 count = 1, i_deqReady_2 = 2'b11 -> only one pop; o_deqValid_2 = 00 next cycle; slot1 never pops alone (ready = 2'b10 pops nothing).
REQ-035 count = 5 with a bundle of 3 offered and i_flush = 1 in the same cycle -> count = 0, nothing enqueued; a bundle on the next cycle lands at index 0.
REQ-036 count = 16 with pop 2 and offer count 2 in the same cycle -> offer rejected (conservative rule); count = 14.
